// File: rtl/cci_mem_responder.sv
// rtl/cci_mem_responder.sv - FIU-side CCI memory responder backed by an on-chip line RAM
//
// Accepts read and write line requests, services them from a simple dual-port line RAM and
// returns read beats and write acks tagged with the requester's mdata.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rd_req_*                        read request (valid/addr/len/mdata), rd_req_almfull back-pressure
//   rd_rsp_*                        read data beats (valid/data/mdata/cl_num/eop)
//   wr_req_*                        write beats (valid/addr/data/len/sop/mdata), wr_req_almfull back-pressure
//   wr_rsp_valid, wr_rsp_mdata      one ack per completed write packet
//   err_protocol                    sticky protocol-error flag
module cci_mem_responder #(
    parameter int LINE_ADDR_W  = 42,
    parameter int RAM_IDX_W    = 10,
    parameter int DATA_W       = 512,
    parameter int MDATA_W      = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int ALM_FULL_GAP = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_req_valid,
    input  logic [LINE_ADDR_W-1:0] rd_req_addr,
    input  logic [1:0]             rd_req_len,
    input  logic [MDATA_W-1:0]     rd_req_mdata,
    output logic                   rd_req_almfull,
    output logic                   rd_rsp_valid,
    output logic [DATA_W-1:0]      rd_rsp_data,
    output logic [MDATA_W-1:0]     rd_rsp_mdata,
    output logic [1:0]             rd_rsp_cl_num,
    output logic                   rd_rsp_eop,
    input  logic                   wr_req_valid,
    input  logic [LINE_ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0]      wr_req_data,
    input  logic [1:0]             wr_req_len,
    input  logic                   wr_req_sop,
    input  logic [MDATA_W-1:0]     wr_req_mdata,
    output logic                   wr_req_almfull,
    output logic                   wr_rsp_valid,
    output logic [MDATA_W-1:0]     wr_rsp_mdata,
    output logic                   err_protocol
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RAM_DEPTH = 1 << RAM_IDX_W;

    localparam logic [0:0] RD_IDLE  = 1'b0;
    localparam logic [0:0] RD_BURST = 1'b1;
    localparam logic [0:0] WR_IDLE  = 1'b0;
    localparam logic [0:0] WR_PKT   = 1'b1;

    // Index of the last beat in a packet; the illegal encoding 2 is serviced as one line.
    function automatic logic [1:0] last_beat(input logic [1:0] len);
        return (len == 2'd2) ? 2'd0 : len;
    endfunction

    function automatic logic bad_req(input logic [1:0] len, input logic [1:0] a);
        return (len == 2'd2) || (len == 2'd1 && a[0]) || (len == 2'd3 && a != 2'd0);
    endfunction

    // Only the RAM index bits of an address are meaningful; higher bits alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{rd_req_addr[LINE_ADDR_W-1:RAM_IDX_W], wr_req_addr[LINE_ADDR_W-1:RAM_IDX_W]};

    // ---------------- read request FIFO ----------------
    logic [RAM_IDX_W-1:0] rq_addr  [FIFO_DEPTH];
    logic [1:0]           rq_len   [FIFO_DEPTH];
    logic [MDATA_W-1:0]   rq_mdata [FIFO_DEPTH];
    logic [PTR_W-1:0]     rq_wp, rq_rp;
    logic [CNT_W-1:0]     rq_cnt;
    logic                 rq_full, rq_empty, rq_push, rq_pop;

    assign rq_full        = (rq_cnt == CNT_W'(FIFO_DEPTH));
    assign rq_empty       = (rq_cnt == '0);
    assign rq_push        = rd_req_valid && !rq_full;
    assign rd_req_almfull = (rq_cnt >= CNT_W'(FIFO_DEPTH - ALM_FULL_GAP));

    always_ff @(posedge clk) begin
        if (rq_push) begin
            rq_addr[rq_wp]  <= rd_req_addr[RAM_IDX_W-1:0];
            rq_len[rq_wp]   <= rd_req_len;
            rq_mdata[rq_wp] <= rd_req_mdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rq_wp  <= '0;
            rq_rp  <= '0;
            rq_cnt <= '0;
        end else begin
            if (rq_push) rq_wp <= rq_wp + PTR_W'(1);
            if (rq_pop)  rq_rp <= rq_rp + PTR_W'(1);
            rq_cnt <= rq_cnt + CNT_W'(rq_push) - CNT_W'(rq_pop);
        end
    end

    // ---------------- write beat FIFO ----------------
    logic [RAM_IDX_W-1:0] wq_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0]    wq_data  [FIFO_DEPTH];
    logic [1:0]           wq_len   [FIFO_DEPTH];
    logic                 wq_sop   [FIFO_DEPTH];
    logic [MDATA_W-1:0]   wq_mdata [FIFO_DEPTH];
    logic [PTR_W-1:0]     wq_wp, wq_rp;
    logic [CNT_W-1:0]     wq_cnt;
    logic                 wq_full, wq_push, wq_pop;

    assign wq_full        = (wq_cnt == CNT_W'(FIFO_DEPTH));
    assign wq_push        = wr_req_valid && !wq_full;
    assign wq_pop         = (wq_cnt != '0);
    assign wr_req_almfull = (wq_cnt >= CNT_W'(FIFO_DEPTH - ALM_FULL_GAP));

    always_ff @(posedge clk) begin
        if (wq_push) begin
            wq_addr[wq_wp]  <= wr_req_addr[RAM_IDX_W-1:0];
            wq_data[wq_wp]  <= wr_req_data;
            wq_len[wq_wp]   <= wr_req_len;
            wq_sop[wq_wp]   <= wr_req_sop;
            wq_mdata[wq_wp] <= wr_req_mdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (wq_push) wq_wp <= wq_wp + PTR_W'(1);
            if (wq_pop)  wq_rp <= wq_rp + PTR_W'(1);
            wq_cnt <= wq_cnt + CNT_W'(wq_push) - CNT_W'(wq_pop);
        end
    end

    // ---------------- line RAM ----------------
    logic [DATA_W-1:0]    ram [RAM_DEPTH];
    logic [DATA_W-1:0]    ram_q;
    logic [RAM_IDX_W-1:0] ram_ridx, ram_widx;
    logic                 ram_we;

    // Read and write in one block with non-blocking updates: a same-cycle read of the
    // index being written sees the old line.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_widx] <= wq_data[wq_rp];
        ram_q <= ram[ram_ridx];
    end

    // ---------------- read FSM ----------------
    logic [0:0]           rd_state;
    logic [RAM_IDX_W-1:0] rd_base;
    logic [1:0]           rd_nlast, rd_beat;
    logic [MDATA_W-1:0]   rd_mdata;
    logic                 burst_last, rd_err;
    logic                 iss_valid, iss_eop;
    logic [MDATA_W-1:0]   iss_mdata;
    logic [1:0]           iss_cl;

    assign burst_last = (rd_state == RD_BURST) && (rd_beat == rd_nlast);
    assign rq_pop     = !rq_empty && ((rd_state == RD_IDLE) || burst_last);
    assign rd_err     = rq_pop && bad_req(rq_len[rq_rp], rq_addr[rq_rp][1:0]);

    // From IDLE, beat 0 is read straight from the FIFO head so the minimum latency stays
    // at three cycles; later beats and follow-on packets come from the latched packet.
    always_comb begin
        iss_valid = 1'b0;
        ram_ridx  = rq_addr[rq_rp];
        iss_mdata = rq_mdata[rq_rp];
        iss_cl    = 2'd0;
        iss_eop   = (last_beat(rq_len[rq_rp]) == 2'd0);
        if (rd_state == RD_BURST) begin
            iss_valid = 1'b1;
            ram_ridx  = rd_base + RAM_IDX_W'(rd_beat);
            iss_mdata = rd_mdata;
            iss_cl    = rd_beat;
            iss_eop   = (rd_beat == rd_nlast);
        end else if (rq_pop) begin
            iss_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rd_beat  <= '0;
            rd_nlast <= '0;
            rd_base  <= '0;
            rd_mdata <= '0;
        end else begin
            if (rq_pop) begin
                rd_base  <= rq_addr[rq_rp];
                rd_nlast <= last_beat(rq_len[rq_rp]);
                rd_mdata <= rq_mdata[rq_rp];
            end
            if (rd_state == RD_IDLE) begin
                if (rq_pop) begin
                    rd_beat  <= 2'd1;
                    rd_state <= (last_beat(rq_len[rq_rp]) == 2'd0) ? RD_IDLE : RD_BURST;
                end
            end else if (burst_last) begin
                rd_beat <= 2'd0;
                if (!rq_pop) rd_state <= RD_IDLE;
            end else begin
                rd_beat <= rd_beat + 2'd1;
            end
        end
    end

    // Two-stage response pipe aligned with the registered RAM output.
    logic               p1_valid, p1_eop;
    logic [MDATA_W-1:0] p1_mdata;
    logic [1:0]         p1_cl;

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_valid      <= 1'b0;
            p1_mdata      <= '0;
            p1_cl         <= '0;
            p1_eop        <= 1'b0;
            rd_rsp_valid  <= 1'b0;
            rd_rsp_data   <= '0;
            rd_rsp_mdata  <= '0;
            rd_rsp_cl_num <= '0;
            rd_rsp_eop    <= 1'b0;
        end else begin
            p1_valid      <= iss_valid;
            p1_mdata      <= iss_mdata;
            p1_cl         <= iss_cl;
            p1_eop        <= iss_eop;
            rd_rsp_valid  <= p1_valid;
            rd_rsp_data   <= p1_valid ? ram_q : '0;
            rd_rsp_mdata  <= p1_valid ? p1_mdata : '0;
            rd_rsp_cl_num <= p1_valid ? p1_cl : 2'd0;
            rd_rsp_eop    <= p1_valid && p1_eop;
        end
    end

    // ---------------- write FSM ----------------
    logic [0:0]           wr_state;
    logic [RAM_IDX_W-1:0] wr_base;
    logic [1:0]           wr_nlast, wr_beat;
    logic [MDATA_W-1:0]   wr_mdata;
    logic                 wh_sop, wr_err;

    assign wh_sop = wq_sop[wq_rp];
    assign wr_err = wq_pop && ((wh_sop && (wr_state == WR_PKT))
                            || (!wh_sop && (wr_state == WR_IDLE))
                            || (wh_sop && bad_req(wq_len[wq_rp], wq_addr[wq_rp][1:0])));

    always_comb begin
        ram_we   = 1'b0;
        ram_widx = wq_addr[wq_rp];
        if (wq_pop) begin
            if (wh_sop) begin
                ram_we = 1'b1;
            end else if (wr_state == WR_PKT) begin
                ram_we   = 1'b1;
                ram_widx = wr_base + RAM_IDX_W'(wr_beat);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state     <= WR_IDLE;
            wr_beat      <= '0;
            wr_nlast     <= '0;
            wr_base      <= '0;
            wr_mdata     <= '0;
            wr_rsp_valid <= 1'b0;
            wr_rsp_mdata <= '0;
        end else begin
            wr_rsp_valid <= 1'b0;
            wr_rsp_mdata <= '0;
            if (wq_pop) begin
                if (wh_sop) begin
                    // An SOP always starts a fresh packet, abandoning any unfinished one.
                    wr_base  <= wq_addr[wq_rp];
                    wr_nlast <= last_beat(wq_len[wq_rp]);
                    wr_mdata <= wq_mdata[wq_rp];
                    wr_beat  <= 2'd1;
                    if (last_beat(wq_len[wq_rp]) == 2'd0) begin
                        wr_rsp_valid <= 1'b1;
                        wr_rsp_mdata <= wq_mdata[wq_rp];
                        wr_state     <= WR_IDLE;
                    end else begin
                        wr_state <= WR_PKT;
                    end
                end else if (wr_state == WR_PKT) begin
                    if (wr_beat == wr_nlast) begin
                        wr_rsp_valid <= 1'b1;
                        wr_rsp_mdata <= wr_mdata;
                        wr_state     <= WR_IDLE;
                    end else begin
                        wr_beat <= wr_beat + 2'd1;
                    end
                end
            end
        end
    end

    // ---------------- sticky error ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            err_protocol <= 1'b0;
        end else if ((rd_req_valid && rq_full) || (wr_req_valid && wq_full) || rd_err || wr_err) begin
            err_protocol <= 1'b1;
        end
    end

endmodule
